// File: rtl/slot_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// slot_pkg : shared states, win modes, payouts and LFSR constants. Rev 1.0
// ------------------------------------------------------------------------
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_CLASSIC = 2'd0,
    MODE_PAIRS   = 2'd1,
    MODE_JACKPOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam logic [7:0] PAY_ALL     = 8'd10;
  localparam logic [7:0] PAY_PAIR    = 8'd2;
  localparam logic [7:0] PAY_JACKPOT = 8'd50;
  localparam int         LUCKY_SYM   = 7;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_reel.sv
`default_nettype none
// ------------------------------------------------------------------------
// slot_reel : modulo-NUM_SYMBOLS reel counter advancing by STEP. Rev 1.0
// ------------------------------------------------------------------------
module slot_reel #(
  parameter int NUM_SYMBOLS = 10,
  parameter int SYM_W       = 4,
  parameter int STEP        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance_i,
  output logic [SYM_W-1:0] sym_o
);

  localparam int C_W = SYM_W + 1;

  logic [SYM_W-1:0] sym_q, sym_d;
  logic [C_W-1:0]   w_sum;

  always_comb begin
    w_sum = {1'b0, sym_q} + C_W'(STEP);
    sym_d = sym_q;
    if (advance_i) begin
      if (w_sum >= C_W'(NUM_SYMBOLS)) begin
        sym_d = SYM_W'(w_sum - C_W'(NUM_SYMBOLS));
      end else begin
        sym_d = w_sum[SYM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q <= '0;
    end else begin
      sym_q <= sym_d;
    end
  end

  assign sym_o = sym_q;

endmodule
`default_nettype wire

// File: rtl/slot_machine_core.sv
`default_nettype none
// ------------------------------------------------------------------------
// slot_machine_core : staggered multi-reel slot machine with credits. Rev 1.0
// ------------------------------------------------------------------------
module slot_machine_core
  import slot_pkg::*;
#(
  parameter int NUM_REELS    = 3,
  parameter int NUM_SYMBOLS  = 10,
  parameter int SYM_W        = 4,
  parameter int SPIN_CYCLES  = 10,
  parameter int STOP_GAP     = 5,
  parameter int JITTER_BITS  = 0,
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [1:0]                 mode_i,
  output logic [NUM_REELS*SYM_W-1:0] out_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       won_o,
  output logic [7:0]                 payout_o,
  output logic [CREDIT_W-1:0]        credits_o,
  output logic                       reject_o
);

  localparam int C_LEN_MAX = SPIN_CYCLES + (NUM_REELS - 1) * STOP_GAP + (1 << JITTER_BITS) - 1;
  localparam int C_CNT_W   = $clog2(C_LEN_MAX + 1);
  localparam int C_SUM_W   = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
  localparam logic [C_SUM_W-1:0] C_CREDIT_MAX = {{(C_SUM_W - CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [CREDIT_W-1:0]   credits_q, credits_d;
  logic [7:0]            payout_q, payout_d;
  logic                  won_q, won_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  reject_q, reject_d;

  logic                  w_accept;
  logic [C_CNT_W-1:0]    w_jitter;
  logic [C_CNT_W-1:0]    w_len [NUM_REELS];
  logic [SYM_W-1:0]      w_sym [NUM_REELS];
  logic                  w_all_eq, w_pair, w_lucky;
  logic [7:0]            w_payout;
  logic [C_SUM_W-1:0]    w_sum;

  // Jitter is frozen at acceptance so every reel sees the same extension.
  if (JITTER_BITS > 0) begin : g_jitter
    logic [JITTER_BITS-1:0] jit_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        jit_q <= '0;
      end else if (w_accept) begin
        jit_q <= lfsr_q[JITTER_BITS-1:0];
      end
    end
    assign w_jitter = C_CNT_W'(jit_q);
  end else begin : g_no_jitter
    assign w_jitter = '0;
  end

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    logic w_adv;
    assign w_len[i] = C_CNT_W'(SPIN_CYCLES + i * STOP_GAP) + w_jitter;
    assign w_adv    = (state_q == SPIN) && (cnt_q < w_len[i]);

    slot_reel #(
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .SYM_W       (SYM_W),
      .STEP        ((i + 1) % NUM_SYMBOLS)
    ) u_reel (
      .clk       (clk),
      .rst       (rst),
      .advance_i (w_adv),
      .sym_o     (w_sym[i])
    );

    assign out_o[i*SYM_W +: SYM_W] = w_sym[i];
  end

  always_comb begin
    w_all_eq = 1'b1;
    w_pair   = 1'b0;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (w_sym[i] != w_sym[0])   w_all_eq = 1'b0;
      if (w_sym[i] == w_sym[i-1]) w_pair   = 1'b1;
    end
    w_lucky  = w_all_eq && (w_sym[0] == SYM_W'(LUCKY_SYM));
    w_payout = '0;
    case (mode_q)
      MODE_PAIRS: begin
        if (w_all_eq)    w_payout = PAY_ALL;
        else if (w_pair) w_payout = PAY_PAIR;
      end
      MODE_JACKPOT: begin
        if (w_lucky)       w_payout = PAY_JACKPOT;
        else if (w_all_eq) w_payout = PAY_ALL;
      end
      default: begin
        if (w_all_eq) w_payout = PAY_ALL;
      end
    endcase
    w_sum = C_SUM_W'(credits_q) + C_SUM_W'(w_payout);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    credits_d = credits_q;
    payout_d  = payout_q;
    won_d     = won_q;
    done_d    = 1'b0;
    reject_d  = 1'b0;
    busy_d    = (state_q == SPIN);
    w_accept  = 1'b0;
    lfsr_d    = lfsr_step(lfsr_q);

    case (state_q)
      IDLE, RESULT: begin
        if (start_i) begin
          if (credits_q != '0) begin
            w_accept  = 1'b1;
            state_d   = SPIN;
            mode_d    = mode_e'(mode_i);
            cnt_d     = '0;
            credits_d = credits_q - CREDIT_W'(1);
            won_d     = 1'b0;
            payout_d  = '0;
          end else begin
            reject_d  = 1'b1;
          end
        end
      end
      SPIN: begin
        cnt_d = cnt_q + C_CNT_W'(1);
        if (cnt_q == w_len[NUM_REELS-1] - C_CNT_W'(1)) state_d = EVAL;
      end
      EVAL: begin
        state_d   = RESULT;
        payout_d  = w_payout;
        won_d     = (w_payout != '0);
        done_d    = 1'b1;
        credits_d = (w_sum > C_CREDIT_MAX) ? {CREDIT_W{1'b1}} : w_sum[CREDIT_W-1:0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_CLASSIC;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      credits_q <= CREDIT_W'(INIT_CREDITS);
      payout_q  <= '0;
      won_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      credits_q <= credits_d;
      payout_q  <= payout_d;
      won_q     <= won_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      reject_q  <= reject_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign won_o     = won_q;
  assign payout_o  = payout_q;
  assign credits_o = credits_q;
  assign reject_o  = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_machine_core.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_slot_machine_core : directed checks on four parameterisations. Rev 1.0
// ------------------------------------------------------------------------
module tb_slot_machine_core;
  import slot_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       s_a, s_b, s_c, s_d;

  logic [11:0] o_a, o_b, o_c, o_d;
  logic        b_a, b_b, b_c, b_d;
  logic        d_a, d_b, d_c, d_d;
  logic        w_a, w_b, w_c, w_d;
  logic [7:0]  p_a, p_b, p_c, p_d;
  logic [7:0]  c_a, c_b, c_c;
  logic [3:0]  c_d;
  logic        r_a, r_b, r_c, r_d;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  slot_machine_core u_a (
    .clk(clk), .rst(rst), .start_i(s_a), .mode_i(mode), .out_o(o_a), .busy_o(b_a),
    .done_o(d_a), .won_o(w_a), .payout_o(p_a), .credits_o(c_a), .reject_o(r_a)
  );

  slot_machine_core #(.SPIN_CYCLES(4), .STOP_GAP(2)) u_b (
    .clk(clk), .rst(rst), .start_i(s_b), .mode_i(mode), .out_o(o_b), .busy_o(b_b),
    .done_o(d_b), .won_o(w_b), .payout_o(p_b), .credits_o(c_b), .reject_o(r_b)
  );

  slot_machine_core #(.INIT_CREDITS(0)) u_c (
    .clk(clk), .rst(rst), .start_i(s_c), .mode_i(mode), .out_o(o_c), .busy_o(b_c),
    .done_o(d_c), .won_o(w_c), .payout_o(p_c), .credits_o(c_c), .reject_o(r_c)
  );

  slot_machine_core #(.CREDIT_W(4), .INIT_CREDITS(15)) u_d (
    .clk(clk), .rst(rst), .start_i(s_d), .mode_i(mode), .out_o(o_d), .busy_o(b_d),
    .done_o(d_d), .won_o(w_d), .payout_o(p_d), .credits_o(c_d), .reject_o(r_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0;
    s_a = 1'b0; s_b = 1'b0; s_c = 1'b0; s_d = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_out",     32'(o_a), 32'h0);
    chk("rst_busy",    32'(b_a), 32'h0);
    chk("rst_done",    32'(d_a), 32'h0);
    chk("rst_won",     32'(w_a), 32'h0);
    chk("rst_payout",  32'(p_a), 32'h0);
    chk("rst_reject",  32'(r_a), 32'h0);
    chk("rst_credits", 32'(c_a), 32'd5);

    // Classic spin; start is pulsed again mid-spin and must be ignored.
    mode = 2'd0; s_a = 1'b1;
    tick();
    s_a = 1'b0;
    chk("A_debit", 32'(c_a), 32'd4);
    chk("A_busy0", 32'(b_a), 32'h0);
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 7) s_a = 1'b1;
      if (n == 9) s_a = 1'b0;
      chk("A_busy",   32'(b_a), 32'(n <= 20));
      chk("A_done",   32'(d_a), 32'(n == 21));
      chk("A_reject", 32'(r_a), 32'h0);
      if (n == 5)  chk("A_out_n5",  32'(o_a), 32'h505);
      if (n == 12) chk("A_out_n12", 32'(o_a), 32'h640);
      if (n == 20) chk("A_credits_spin", 32'(c_a), 32'd4);
    end
    chk("A_won",     32'(w_a), 32'h1);
    chk("A_payout",  32'(p_a), 32'd10);
    chk("A_credits", 32'(c_a), 32'd14);
    chk("A_out",     32'(o_a), 32'h0);
    tick();
    chk("A_done_pulse", 32'(d_a), 32'h0);
    chk("A_won_hold",   32'(w_a), 32'h1);
    chk("A_pay_hold",   32'(p_a), 32'd10);

    // Pairs mode with short spin: lengths 4/6/8 give reels (4,2,4), no win.
    mode = 2'd1; s_b = 1'b1;
    tick();
    s_b = 1'b0;
    chk("B_debit", 32'(c_b), 32'd4);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("B_done", 32'(d_b), 32'(n == 9));
      chk("B_busy", 32'(b_b), 32'(n <= 8));
    end
    chk("B_out",     32'(o_b), 32'h424);
    chk("B_won",     32'(w_b), 32'h0);
    chk("B_payout",  32'(p_b), 32'h0);
    chk("B_credits", 32'(c_b), 32'd4);

    // Zero credits: start is refused with a single reject pulse.
    chk("C_credits0", 32'(c_c), 32'd0);
    s_c = 1'b1;
    tick();
    s_c = 1'b0;
    chk("C_reject",  32'(r_c), 32'h1);
    chk("C_state",   32'(u_c.state_q), 32'(IDLE));
    chk("C_busy",    32'(b_c), 32'h0);
    tick();
    chk("C_reject_pulse", 32'(r_c), 32'h0);
    chk("C_out",     32'(o_c), 32'h0);
    chk("C_credits", 32'(c_c), 32'd0);

    // Four-bit credits saturate at 15 instead of reaching 24.
    mode = 2'd0; s_d = 1'b1;
    tick();
    s_d = 1'b0;
    chk("D_debit", 32'(c_d), 32'd14);
    for (int n = 1; n <= 21; n++) begin
      tick();
      chk("D_done", 32'(d_d), 32'(n == 21));
    end
    chk("D_won",     32'(w_d), 32'h1);
    chk("D_credits", 32'(c_d), 32'd15);

    // Held start in jackpot mode: all-zero reels pay PAY_ALL; re-accept on done.
    mode = 2'd2; s_a = 1'b1;
    tick();
    chk("H_debit", 32'(c_a), 32'd13);
    chk("H_done0", 32'(d_a), 32'h0);
    for (int n = 1; n <= 21; n++) begin
      tick();
      chk("H_done", 32'(d_a), 32'(n == 21));
    end
    chk("H_won",     32'(w_a), 32'h1);
    chk("H_payout",  32'(p_a), 32'd10);
    chk("H_credits", 32'(c_a), 32'd23);
    tick();
    s_a = 1'b0;
    chk("H_reaccept", 32'(c_a), 32'd22);
    chk("H_won_clr",  32'(w_a), 32'h0);
    chk("H_pay_clr",  32'(p_a), 32'h0);
    chk("H_done_clr", 32'(d_a), 32'h0);

    // Reset in the middle of that spin aborts it without refund.
    for (int n = 1; n <= 7; n++) tick();
    chk("R_out_n7",  32'(o_a), 32'h147);
    chk("R_busy_n7", 32'(b_a), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("R_out",     32'(o_a), 32'h0);
    chk("R_busy",    32'(b_a), 32'h0);
    chk("R_state",   32'(u_a.state_q), 32'(IDLE));
    chk("R_credits", 32'(c_a), 32'd5);
    chk("R_done",    32'(d_a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
